sc_scbc_sof_trk: RTL and testbench

Device-side Start-of-Frame tracker; the receiving end of the host frame counter.
- Consumes decoded SOF token strobes and frame numbers from the packet receiver.
- Measures the SOF interval, checks timing and sequence, and locks after consecutive good frames.
- Maintains a local frame number and frame tick that keep running across missed SOFs; feeds device-side scheduling and isochronous logic on the ULPI clock domain.

---
 rtl/sc_scbc_pkg.sv | 25 ++
 rtl/sc_scbc_sof_trk.sv | 254 +++++++++++++++++++++++++
 tb/tb_sc_scbc_sof_trk.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sc_scbc_pkg.sv
// sc_scbc_pkg
// Shared types and helpers for the SCBC start-of-frame logic.
//   sof_trk_state_t : SOF tracker state encoding (IDLE/SEEK/ACQ/LOCKED)
//   FRNUM_WRAP_MAX  : last frame number before wrap in short-wrap mode
//   frnum_next()    : successor of a frame number for the selected wrap mode
package sc_scbc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEEK   = 2'd1,
        ACQ    = 2'd2,
        LOCKED = 2'd3
    } sof_trk_state_t;

    localparam logic [15:0] FRNUM_WRAP_MAX = 16'h03F7;

    // mode=1: 0x03F7 wraps to 0; otherwise plain 16-bit increment.
    function automatic logic [15:0] frnum_next(input logic [15:0] num, input logic mode);
        if (mode && (num == FRNUM_WRAP_MAX)) begin
            return '0;
        end
        return num + 16'd1;
    endfunction

endpackage

// File: rtl/sc_scbc_sof_trk.sv
// sc_scbc_sof_trk
// Device-side Start-of-Frame tracker. Measures the spacing of received SOF
// tokens, checks timing/sequence, locks after LOCK_COUNT consecutive good
// frames and keeps a local frame number / tick running across missed SOFs.
//
// Ports
//   ULPICLK, ULPIRSTB     clock, synchronous active-low reset
//   UPS_OPERATIONAL       link up; low forces IDLE
//   SOF_VALID/SOF_NUMBER  decoded SOF strobe and its frame number
//   SF_ENABLE             tracker enable; low forces IDLE
//   SF_INTERVAL           nominal SOF period minus 1 (cycles)
//   SF_TOLERANCE          allowed deviation (cycles)
//   SF_MODE               1: frame number wraps 0x03F7->0, 0: 16-bit wrap
//   SF_STATE/SF_LOCKED    tracker state, lock flag
//   SF_NUMBER             local frame number
//   SF_TICK               pulse on every frame boundary (real or synthesized)
//   SF_MISSED             pulse on a synthesized boundary
//   SF_SEQERR             pulse, in-window SOF with unexpected number (LOCKED)
//   SF_TIMERR             pulse, SOF outside the window in ACQ/LOCKED
//   SF_MEASURED           interval count at the last in-window SOF
//   SF_MISS_CNT           saturating count of synthesized boundaries
// Optional (macro SC_SCBC_SOF_TRK_STAT_EN):
//   SF_SEQERR_CNT, SF_TIMERR_CNT  saturating error-pulse counters
module sc_scbc_sof_trk
    import sc_scbc_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned MISS_LIMIT = 3
) (
    input  logic        ULPICLK,
    input  logic        ULPIRSTB,
    input  logic        UPS_OPERATIONAL,
    input  logic        SOF_VALID,
    input  logic [15:0] SOF_NUMBER,
    input  logic        SF_ENABLE,
    input  logic [15:0] SF_INTERVAL,
    input  logic [7:0]  SF_TOLERANCE,
    input  logic        SF_MODE,
    output logic [1:0]  SF_STATE,
    output logic        SF_LOCKED,
    output logic [15:0] SF_NUMBER,
    output logic        SF_TICK,
    output logic        SF_MISSED,
    output logic        SF_SEQERR,
    output logic        SF_TIMERR,
    output logic [15:0] SF_MEASURED,
    output logic [7:0]  SF_MISS_CNT
`ifdef SC_SCBC_SOF_TRK_STAT_EN
    ,
    output logic [7:0]  SF_SEQERR_CNT,
    output logic [7:0]  SF_TIMERR_CNT
`endif
);

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
    localparam logic [3:0] MISS_LIM = 4'(MISS_LIMIT);

    sof_trk_state_t state_q, state_d;
    logic        locked_q,   locked_d;
    logic [15:0] icnt_q,     icnt_d;
    logic [3:0]  good_q,     good_d;
    logic [3:0]  miss_run_q, miss_run_d;
    logic [15:0] number_q,   number_d;
    logic [15:0] measured_q, measured_d;
    logic [7:0]  miss_cnt_q, miss_cnt_d;
    logic        tick_q,     tick_d;
    logic        missed_q,   missed_d;
    logic        seqerr_q,   seqerr_d;
    logic        timerr_q,   timerr_d;
    logic [7:0]  seqerr_cnt_q, seqerr_cnt_d;
    logic [7:0]  timerr_cnt_q, timerr_cnt_d;

    logic        kill;
    logic [15:0] win_lo;
    logic [16:0] win_hi;
    logic        in_win;
    logic        at_thr;
    logic [15:0] nxt;
    logic        seq_ok;

    assign kill   = !SF_ENABLE || !UPS_OPERATIONAL;
    assign win_lo = (SF_INTERVAL >= {8'h00, SF_TOLERANCE}) ?
                    (SF_INTERVAL - {8'h00, SF_TOLERANCE}) : '0;
    assign win_hi = {1'b0, SF_INTERVAL} + {9'h000, SF_TOLERANCE};
    assign in_win = (icnt_q >= win_lo) && ({1'b0, icnt_q} <= win_hi);
    // ICNT saturates at 0xFFFF, so a threshold above that never fires.
    assign at_thr = ({1'b0, icnt_q} == (win_hi + 17'd1));
    assign nxt    = frnum_next(number_q, SF_MODE);
    assign seq_ok = (SOF_NUMBER == nxt);

    always_comb begin
        state_d    = state_q;
        icnt_d     = (icnt_q == 16'hFFFF) ? icnt_q : icnt_q + 16'd1;
        good_d     = good_q;
        miss_run_d = miss_run_q;
        number_d   = number_q;
        measured_d = measured_q;
        miss_cnt_d = miss_cnt_q;
        tick_d     = 1'b0;
        missed_d   = 1'b0;
        seqerr_d   = 1'b0;
        timerr_d   = 1'b0;

        if (kill) begin
            state_d    = IDLE;
            icnt_d     = '0;
            good_d     = '0;
            miss_run_d = '0;
            number_d   = '0;
            measured_d = '0;
            miss_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = SEEK;
                    icnt_d  = '0;
                end
                SEEK: begin
                    if (SOF_VALID) begin
                        tick_d   = 1'b1;
                        icnt_d   = '0;
                        number_d = SOF_NUMBER;
                        good_d   = 4'd1;
                        state_d  = ACQ;
                    end
                end
                ACQ: begin
                    if (SOF_VALID) begin
                        tick_d   = 1'b1;
                        icnt_d   = '0;
                        number_d = SOF_NUMBER;
                        if (in_win) begin
                            measured_d = icnt_q;
                        end else begin
                            timerr_d = 1'b1;
                        end
                        if (in_win && seq_ok) begin
                            good_d = good_q + 4'd1;
                            if ((good_q + 4'd1) >= LOCK_CNT) begin
                                state_d    = LOCKED;
                                miss_run_d = '0;
                            end
                        end else begin
                            good_d = 4'd1;
                        end
                    end else if (at_thr) begin
                        state_d = SEEK;
                    end
                end
                LOCKED: begin
                    if (SOF_VALID) begin
                        tick_d   = 1'b1;
                        icnt_d   = '0;
                        number_d = SOF_NUMBER;
                        if (in_win) begin
                            measured_d = icnt_q;
                            miss_run_d = '0;
                            seqerr_d   = !seq_ok;
                        end else begin
                            timerr_d = 1'b1;
                            good_d   = 4'd1;
                            state_d  = ACQ;
                        end
                    end else if (at_thr) begin
                        // Synthesized boundary: restart ICNT at TOL+1 so the
                        // next nominal boundary stays at the original phase.
                        tick_d     = 1'b1;
                        missed_d   = 1'b1;
                        number_d   = nxt;
                        icnt_d     = {8'h00, SF_TOLERANCE} + 16'd1;
                        miss_run_d = miss_run_q + 4'd1;
                        if (miss_cnt_q != 8'hFF) begin
                            miss_cnt_d = miss_cnt_q + 8'd1;
                        end
                        if ((miss_run_q + 4'd1) >= MISS_LIM) begin
                            state_d = SEEK;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        locked_d = (state_d == LOCKED);

        seqerr_cnt_d = seqerr_cnt_q;
        timerr_cnt_d = timerr_cnt_q;
        if (kill) begin
            seqerr_cnt_d = '0;
            timerr_cnt_d = '0;
        end else begin
            if (seqerr_d && (seqerr_cnt_q != 8'hFF)) begin
                seqerr_cnt_d = seqerr_cnt_q + 8'd1;
            end
            if (timerr_d && (timerr_cnt_q != 8'hFF)) begin
                timerr_cnt_d = timerr_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge ULPICLK) begin
        if (!ULPIRSTB) begin
            state_q      <= IDLE;
            locked_q     <= 1'b0;
            icnt_q       <= '0;
            good_q       <= '0;
            miss_run_q   <= '0;
            number_q     <= '0;
            measured_q   <= '0;
            miss_cnt_q   <= '0;
            tick_q       <= 1'b0;
            missed_q     <= 1'b0;
            seqerr_q     <= 1'b0;
            timerr_q     <= 1'b0;
            seqerr_cnt_q <= '0;
            timerr_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            locked_q     <= locked_d;
            icnt_q       <= icnt_d;
            good_q       <= good_d;
            miss_run_q   <= miss_run_d;
            number_q     <= number_d;
            measured_q   <= measured_d;
            miss_cnt_q   <= miss_cnt_d;
            tick_q       <= tick_d;
            missed_q     <= missed_d;
            seqerr_q     <= seqerr_d;
            timerr_q     <= timerr_d;
            seqerr_cnt_q <= seqerr_cnt_d;
            timerr_cnt_q <= timerr_cnt_d;
        end
    end

    assign SF_STATE    = state_q;
    assign SF_LOCKED   = locked_q;
    assign SF_NUMBER   = number_q;
    assign SF_TICK     = tick_q;
    assign SF_MISSED   = missed_q;
    assign SF_SEQERR   = seqerr_q;
    assign SF_TIMERR   = timerr_q;
    assign SF_MEASURED = measured_q;
    assign SF_MISS_CNT = miss_cnt_q;

`ifdef SC_SCBC_SOF_TRK_STAT_EN
    assign SF_SEQERR_CNT = seqerr_cnt_q;
    assign SF_TIMERR_CNT = timerr_cnt_q;
`else
    // Counters are only observable with the statistics option.
    logic unused_stat;
    assign unused_stat = ^{seqerr_cnt_q, timerr_cnt_q};
`endif

endmodule

// File: tb/tb_sc_scbc_sof_trk.sv
// tb_sc_scbc_sof_trk
// Self-checking bench for sc_scbc_sof_trk: directed scenarios plus randomized
// SOF streams, compared cycle by cycle against a behavioural model.
// Honours SC_SCBC_SOF_TRK_STAT_EN for the optional error counters.
module tb_sc_scbc_sof_trk;

    localparam int LOCK_N = 3;
    localparam int MISS_N = 3;

    logic        clk = 1'b0;
    logic        rstb;
    logic        op;
    logic        sof_valid;
    logic [15:0] sof_number;
    logic        en;
    logic [15:0] interval;
    logic [7:0]  tol;
    logic        mode;
    logic [1:0]  sf_state;
    logic        sf_locked;
    logic [15:0] sf_number;
    logic        sf_tick;
    logic        sf_missed;
    logic        sf_seqerr;
    logic        sf_timerr;
    logic [15:0] sf_measured;
    logic [7:0]  sf_miss_cnt;
`ifdef SC_SCBC_SOF_TRK_STAT_EN
    logic [7:0]  sf_seqerr_cnt;
    logic [7:0]  sf_timerr_cnt;
`endif

    always #5 clk = ~clk;

    sc_scbc_sof_trk #(.LOCK_COUNT(LOCK_N), .MISS_LIMIT(MISS_N)) dut (
        .ULPICLK        (clk),
        .ULPIRSTB       (rstb),
        .UPS_OPERATIONAL(op),
        .SOF_VALID      (sof_valid),
        .SOF_NUMBER     (sof_number),
        .SF_ENABLE      (en),
        .SF_INTERVAL    (interval),
        .SF_TOLERANCE   (tol),
        .SF_MODE        (mode),
        .SF_STATE       (sf_state),
        .SF_LOCKED      (sf_locked),
        .SF_NUMBER      (sf_number),
        .SF_TICK        (sf_tick),
        .SF_MISSED      (sf_missed),
        .SF_SEQERR      (sf_seqerr),
        .SF_TIMERR      (sf_timerr),
        .SF_MEASURED    (sf_measured),
        .SF_MISS_CNT    (sf_miss_cnt)
`ifdef SC_SCBC_SOF_TRK_STAT_EN
        ,
        .SF_SEQERR_CNT  (sf_seqerr_cnt),
        .SF_TIMERR_CNT  (sf_timerr_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int obs_missed = 0;

    // Model state: 0 idle, 1 seek, 2 acq, 3 locked
    int m_state, m_icnt, m_good, m_run, m_num, m_meas, m_misscnt, m_scnt, m_tcnt;
    bit m_tick, m_missed, m_seqerr, m_timerr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int next_frame(input int n);
        if (mode && n == 16'h03F7) return 0;
        return (n + 1) % 65536;
    endfunction

    task automatic model_clear();
        m_state = 0; m_icnt = 0; m_good = 0; m_run = 0; m_num = 0;
        m_meas = 0; m_misscnt = 0; m_scnt = 0; m_tcnt = 0;
    endtask

    task automatic model_edge();
        int lo, hi, expn, prev;
        bit inwin, thr;
        m_tick = 0; m_missed = 0; m_seqerr = 0; m_timerr = 0;
        if (!rstb || !en || !op) begin
            model_clear();
            return;
        end
        lo = int'(interval) - int'(tol);
        if (lo < 0) lo = 0;
        hi    = int'(interval) + int'(tol);
        inwin = (m_icnt >= lo) && (m_icnt <= hi);
        thr   = (m_icnt == hi + 1);
        expn  = next_frame(m_num);
        prev  = m_icnt;
        m_icnt = (m_icnt < 65535) ? m_icnt + 1 : 65535;
        if (m_state == 0) begin
            m_state = 1;
            m_icnt  = 0;
        end else if (sof_valid) begin
            m_tick = 1; m_icnt = 0; m_num = int'(sof_number);
            if (m_state == 1) begin
                m_good = 1; m_state = 2;
            end else if (!inwin) begin
                m_timerr = 1; m_good = 1; m_state = 2;
            end else begin
                m_meas = prev;
                if (m_state == 3) begin
                    m_run = 0;
                    m_seqerr = (int'(sof_number) != expn);
                end else if (int'(sof_number) == expn) begin
                    m_good++;
                    if (m_good >= LOCK_N) begin
                        m_state = 3; m_run = 0;
                    end
                end else begin
                    m_good = 1;
                end
            end
        end else if (thr && m_state == 2) begin
            m_state = 1;
        end else if (thr && m_state == 3) begin
            m_tick = 1; m_missed = 1; m_num = expn;
            m_icnt = int'(tol) + 1;
            m_run++;
            if (m_misscnt < 255) m_misscnt++;
            if (m_run >= MISS_N) m_state = 1;
        end
        if (m_seqerr && m_scnt < 255) m_scnt++;
        if (m_timerr && m_tcnt < 255) m_tcnt++;
    endtask

    task automatic compare_all();
        check("state",    32'(sf_state),    32'(m_state));
        check("number",   32'(sf_number),   32'(m_num));
        check("measured", 32'(sf_measured), 32'(m_meas));
        check("misscnt",  32'(sf_miss_cnt), 32'(m_misscnt));
        check("flags", {27'd0, sf_locked, sf_tick, sf_missed, sf_seqerr, sf_timerr},
              {27'd0, m_state == 3, m_tick, m_missed, m_seqerr, m_timerr});
`ifdef SC_SCBC_SOF_TRK_STAT_EN
        check("seqerr_cnt", 32'(sf_seqerr_cnt), 32'(m_scnt));
        check("timerr_cnt", 32'(sf_timerr_cnt), 32'(m_tcnt));
`endif
        if (sf_missed) obs_missed++;
    endtask

    task automatic step(input bit sof, input int num);
        sof_valid  = sof;
        sof_number = 16'(num);
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        sof_valid = 1'b0;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0);
    endtask

    // SOF arriving 'gap' cycles after the previous step boundary.
    task automatic sof_gap(input int gap, input int num);
        quiet(gap - 1);
        step(1'b1, num);
    endtask

    task automatic restart();
        en = 1'b0;
        step(1'b0, 0);
        en = 1'b1;
        step(1'b0, 0);
    endtask

    initial begin
        rstb = 1'b0; op = 1'b0; en = 1'b0; sof_valid = 1'b0; sof_number = '0;
        interval = 16'd99; tol = 8'd2; mode = 1'b0;
        model_clear();
        m_tick = 0; m_missed = 0; m_seqerr = 0; m_timerr = 0;
        quiet(3);
        check("rst_state", 32'(sf_state), 32'd0);
        check("rst_outs", {sf_locked, sf_tick, sf_missed, sf_seqerr, sf_timerr, sf_number, sf_measured, sf_miss_cnt}, '0);

        // 1: acquire and lock on 5,6,7 at 100-cycle spacing
        rstb = 1'b1; en = 1'b1; op = 1'b1;
        step(1'b0, 0);
        check("t1_seek", 32'(sf_state), 32'd1);
        step(1'b1, 5);
        check("t1_acq", 32'(sf_state), 32'd2);
        sof_gap(100, 6);
        check("t1_acq2", 32'(sf_state), 32'd2);
        sof_gap(100, 7);
        check("t1_lock", {30'd0, sf_state}, 32'd3);
        check("t1_locked", 32'(sf_locked), 32'd1);
        check("t1_num", 32'(sf_number), 32'd7);
        check("t1_meas", 32'(sf_measured), 32'd99);
        check("t1_tick", 32'(sf_tick), 32'd1);

        // 2: one omitted SOF is synthesized at ICNT==102, next SOF in-window
        quiet(102);
        check("t2_nomiss_yet", 32'(sf_missed), 32'd0);
        step(1'b0, 0);
        check("t2_missed", {sf_missed, sf_tick}, 32'd3);
        check("t2_num8", 32'(sf_number), 32'd8);
        sof_gap(97, 9);
        check("t2_errs", {sf_seqerr, sf_timerr}, 32'd0);
        check("t2_num9", 32'(sf_number), 32'd9);
        check("t2_still_locked", 32'(sf_locked), 32'd1);

        // 3: three consecutive omissions drop the lock
        restart();
        step(1'b1, 1); sof_gap(100, 2); sof_gap(100, 3);
        obs_missed = 0;
        quiet(310);
        check("t3_misses", 32'(obs_missed), 32'd3);
        check("t3_seek", 32'(sf_state), 32'd1);
        check("t3_unlocked", 32'(sf_locked), 32'd0);
        check("t3_misscnt", 32'(sf_miss_cnt), 32'd3);

        // 4: short-wrap mode, synthesized boundary wraps 0x03F7 -> 0
        mode = 1'b1;
        step(1'b1, 16'h03F5); sof_gap(100, 16'h03F6); sof_gap(100, 16'h03F7);
        check("t4_lock", 32'(sf_state), 32'd3);
        quiet(103);
        check("t4_wrap", 32'(sf_number), 32'd0);
        sof_gap(97, 1);
        check("t4_noseq", 32'(sf_seqerr), 32'd0);
        check("t4_num1", 32'(sf_number), 32'd1);

        // 5: sequence error keeps lock, early SOF drops to ACQ
        mode = 1'b0;
        restart();
        step(1'b1, 6); sof_gap(100, 7); sof_gap(100, 8);
        sof_gap(100, 20);
        check("t5_seqerr", 32'(sf_seqerr), 32'd1);
        check("t5_num20", 32'(sf_number), 32'd20);
        check("t5_locked", 32'(sf_state), 32'd3);
        sof_gap(97, 21);
        check("t5_timerr", 32'(sf_timerr), 32'd1);
        check("t5_acq", 32'(sf_state), 32'd2);

        // 6: link drop with a coincident SOF forces IDLE
        sof_gap(100, 22); sof_gap(100, 23);
        check("t6_lock", 32'(sf_state), 32'd3);
        op = 1'b0;
        step(1'b1, 24);
        check("t6_idle", 32'(sf_state), 32'd0);
        check("t6_zero", {sf_locked, sf_tick, sf_missed, sf_seqerr, sf_timerr, sf_number, sf_measured, sf_miss_cnt}, '0);
`ifdef SC_SCBC_SOF_TRK_STAT_EN
        check("t6_stat_zero", {sf_seqerr_cnt, sf_timerr_cnt}, '0);
`endif
        op = 1'b1;
        step(1'b0, 0);
        check("t6_seek", 32'(sf_state), 32'd1);

        // Randomized streams: jitter, wrong numbers, omissions, live retuning
        interval = 16'd30; tol = 8'd3;
        for (int f = 0; f < 300; f++) begin
            int r, gap, num, nom;
            r = int'($urandom_range(0, 99));
            if (r < 4) begin
                restart();
            end else if (r < 12) begin
                interval = 16'($urandom_range(1, 40));
                tol      = 8'($urandom_range(0, 6));
                mode     = 1'($urandom_range(0, 1));
            end
            nom = int'(interval) + 1;
            r = int'($urandom_range(0, 99));
            if (r < 60) begin
                gap = nom + int'($urandom_range(0, 2 * int'(tol))) - int'(tol);
            end else if (r < 80) begin
                gap = int'($urandom_range(1, 2 * nom + int'(tol) + 3));
            end else begin
                gap = -1;
            end
            if (gap < 1 && gap != -1) gap = 1;
            r = int'($urandom_range(0, 99));
            if (r < 75)      num = next_frame(m_num);
            else if (r < 85) num = 16'h03F6 + int'($urandom_range(0, 1));
            else             num = int'($urandom_range(0, 65535));
            if (gap == -1) quiet(nom + int'(tol) + 5);
            else           sof_gap(gap, num);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
